// File: rtl/activation_unit_if.sv
// activation_unit_if: input and output valid/ready streams of the activation stage
interface activation_unit_if #(
  parameter int dataWidth = 16,
  parameter int NUM_CH = 4
);
  logic in_valid;
  logic in_ready;
  logic [1:0] in_mode;
  logic [NUM_CH*2*dataWidth-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [NUM_CH*dataWidth-1:0] out_data;
  logic [NUM_CH-1:0] out_sat;
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/activation_unit.sv
// activation_unit: 2-stage multi-channel ReLU/leaky/saturating-linear stage; ACT_ROUND_EN enables round-half-up
module activation_unit #(
  parameter int dataWidth = 16,
  parameter int intWidth = 4,
  parameter int NUM_CH = 4,
  parameter int LEAK_SHIFT = 3
) (
  input logic clk,
  input logic rst_n,
  activation_unit_if.slave io
);
  localparam int W = 2*dataWidth;
`ifdef ACT_ROUND_EN
  localparam logic [W:0] RND = (W+1)'(1) << (dataWidth-intWidth-1);
`else
  localparam logic [W:0] RND = '0;
`endif
  logic s1_valid, s2_valid, s1_load, s2_load;
  logic [1:0] s1_mode;
  logic [NUM_CH*W-1:0] s1_data;
  logic [NUM_CH*dataWidth-1:0] act_data, s2_data;
  logic [NUM_CH-1:0] act_sat, s2_sat;
  assign s2_load = s1_valid && (!s2_valid || io.out_ready);
  assign io.in_ready = !s1_valid || s2_load;
  assign s1_load = io.in_valid && io.in_ready;
  assign io.out_valid = s2_valid;
  assign io.out_data = s2_data;
  assign io.out_sat = s2_sat;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [W-1:0] x, xl, y;
    logic [W:0] ye;
    logic [intWidth+1:0] top;
    logic ovf;
    assign x = s1_data[k*W +: W];
    assign xl = x >>> LEAK_SHIFT;
    assign y = (!x[W-1] || s1_mode == 2'b10) ? x : (s1_mode == 2'b01) ? xl : '0;
    // one guard bit above y keeps a rounding carry out of the sign from wrapping
    assign ye = {y[W-1], y} + RND;
    assign top = ye[W -: intWidth+2];
    assign ovf = |top && !(&top);
    assign act_sat[k] = ovf;
    assign act_data[k*dataWidth +: dataWidth] = !ovf ? dataWidth'(ye >> (W-dataWidth-intWidth)) :
      ye[W] ? {1'b1, {(dataWidth-1){1'b0}}} : {1'b0, {(dataWidth-1){1'b1}}};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_mode <= '0;
      s1_data <= '0;
      s2_data <= '0;
      s2_sat <= '0;
    end else begin
      if (s1_load) begin
        s1_data <= io.in_data;
        s1_mode <= io.in_mode;
      end
      if (s2_load) begin
        s2_data <= act_data;
        s2_sat <= act_sat;
      end
      s1_valid <= s1_load || (s1_valid && !s2_load);
      s2_valid <= s2_load || (s2_valid && !io.out_ready);
    end
  end
endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit: directed vector table plus backpressure and reset sequences
module tb_activation_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  activation_unit_if #(.dataWidth(16), .NUM_CH(4)) bus ();
  activation_unit #(.dataWidth(16), .intWidth(4), .NUM_CH(4), .LEAK_SHIFT(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus.slave)
  );
  always #5 clk = ~clk;
`ifdef ACT_ROUND_EN
  localparam logic [15:0] R_SMALL = 16'h0001;
  localparam logic R_SAT = 1'b1;
`else
  localparam logic [15:0] R_SMALL = 16'h0000;
  localparam logic R_SAT = 1'b0;
`endif
  typedef struct {
    logic [1:0] mode;
    logic [127:0] x;
    logic [63:0] y;
    logic [3:0] sat;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  initial begin
    logic [31:0] bx[6];
    logic [15:0] by[6];
    logic [84:0] prev;
    int sent, rcv, stalls, stale;
    logic held;
    v[0]  = '{2'b00, {4{32'h01000000}}, {4{16'h1000}}, 4'h0};
    v[1]  = '{2'b00, {4{32'hFF000000}}, {4{16'h0000}}, 4'h0};
    v[2]  = '{2'b00, {4{32'h08000000}}, {4{16'h7FFF}}, 4'hF};
    v[3]  = '{2'b01, {4{32'hFF000000}}, {4{16'hFE00}}, 4'h0};
    v[4]  = '{2'b01, {4{32'h00800000}}, {4{16'h0800}}, 4'h0};
    v[5]  = '{2'b10, {4{32'hF7000000}}, {4{16'h8000}}, 4'hF};
    v[6]  = '{2'b10, {4{32'hFF000000}}, {4{16'hF000}}, 4'h0};
    v[7]  = '{2'b10, {4{32'h00000800}}, {4{R_SMALL}}, 4'h0};
    v[8]  = '{2'b10, {4{32'h07FFF800}}, {4{16'h7FFF}}, {4{R_SAT}}};
    v[9]  = '{2'b11, {4{32'hFF000000}}, {4{16'h0000}}, 4'h0};
    v[10] = '{2'b01, {4{32'h80000000}}, {4{16'h8000}}, 4'hF};
    v[11] = '{2'b00, {4{32'h7FFFFFFF}}, {4{16'h7FFF}}, 4'hF};
    v[12] = '{2'b10, {4{32'hFFFFF000}}, {4{16'hFFFF}}, 4'h0};
    v[13] = '{2'b01, {4{32'hF0000000}}, {4{16'hE000}}, 4'h0};
    v[14] = '{2'b01, {32'h08000000, 32'h80000000, 32'hFF000000, 32'h01000000},
              {16'h7FFF, 16'h8000, 16'hFE00, 16'h1000}, 4'b1100};
    bx = '{32'h01000000, 32'hFE000000, 32'h03000000, 32'hFC000000, 32'h05000000, 32'hFA000000};
    by = '{16'h1000, 16'hFC00, 16'h3000, 16'hF800, 16'h5000, 16'hF400};
    bus.in_valid = 1'b0;
    bus.in_mode = 2'b00;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.in_ready, bus.out_valid, bus.out_sat, bus.out_data}, {1'b1, 1'b0, 4'h0, 64'h0});
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_mode = v[i].mode;
      bus.in_data = v[i].x;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("lat1_valid[%0d]", i), bus.out_valid, 1'b0);
      @(negedge clk);
      chk($sformatf("lat2_valid[%0d]", i), bus.out_valid, 1'b1);
      chk($sformatf("data[%0d]", i), bus.out_data, v[i].y);
      chk($sformatf("sat[%0d]", i), bus.out_sat, v[i].sat);
    end
    sent = 0;
    rcv = 0;
    stalls = 0;
    held = 1'b0;
    prev = '0;
    for (int c = 0; c < 80 && rcv < 6; c++) begin
      @(negedge clk);
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      bus.in_valid = sent < 6;
      bus.in_mode = (sent % 2 == 1) ? 2'b01 : 2'b00;
      bus.in_data = {4{bx[sent % 6]}};
      #1;
      if (held) chk("stall_hold", {bus.out_valid, bus.out_sat, bus.out_data}, prev);
      if (!bus.in_ready) begin
        stalls++;
        chk("stall_ready", {bus.out_valid, bus.out_ready}, 2'b10);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_data[%0d]", rcv), {bus.out_sat, bus.out_data}, {4'h0, {4{by[rcv]}}});
        rcv++;
      end
      held = bus.out_valid && !bus.out_ready;
      prev = {bus.out_valid, bus.out_sat, bus.out_data};
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", 128'(rcv), 128'd6);
    chk("bp_stall_seen", stalls > 0, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode = 2'b00;
    bus.in_data = {4{32'h01000000}};
    @(negedge clk);
    bus.in_data = {4{32'h02000000}};
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("inflight_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_state", {bus.in_ready, bus.out_valid, bus.out_sat, bus.out_data}, {1'b1, 1'b0, 4'h0, 64'h0});
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("no_stale", 128'(stale), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
